axil_arb2: RTL and testbench
============================

# axil_arb2

Two-master AXI4-Lite arbiter that shares one AXI4-Lite slave (the QSPI controller register/data port) between two requesters, e.g. the host CPU and the flash-boot DMA. It serialises all traffic: exactly one transaction, read or write, is in flight at any time. Selection is round-robin over four request sources (m0 read, m0 write, m1 read, m1 write). The block sits between the interconnect masters and the QSPI controller's AXI4-Lite slave.

## Interface

- ADDR_W, 32, address width on all ports
- DATA_W, 32, data width; strobe width DATA_W/8
- TIMEOUT_CYC, 256, response watchdog limit (used only with AXIL_ARB_TIMEOUT_EN)
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  reset, synchronous and active-high
- m{0,1}_arvalid/arready/araddr  in/out/in  1/1/ADDR_W  master read-address channel
- m{0,1}_rvalid/rready/rdata/rresp  out/in/out/out  1/1/DATA_W/2  master read-data channel
- m{0,1}_awvalid/awready/awaddr  in/out/in  1/1/ADDR_W  master write-address channel
- m{0,1}_wvalid/wready/wdata/wstrb  in/out/in/in  1/1/DATA_W/DATA_W/8  master write-data channel
- m{0,1}_bvalid/bready/bresp  out/in/out  1/1/2  master write-response channel
- s_ar*, s_r*, s_aw*, s_w*, s_b*  mirrored directions, same widths  slave-side channels to the QSPI controller

## Operation

- Request vector req[3:0] = {m1_awvalid, m1_arvalid, m0_awvalid, m0_arvalid}; a write request needs only awvalid.
- Round-robin pointer ptr[1:0]: search starts at ptr; on grant, ptr <= granted index + 1 (mod 4).
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- IDLE: if any req, register grant (gnt_m, gnt_rw) and move to RD_ADDR or WR_REQ; otherwise stay.
- RD_ADDR: s_arvalid/s_araddr driven from the granted master; granted m_arready = s_arready; on handshake go to RD_DATA.
- RD_DATA: s_rvalid/rdata/rresp routed to the granted master only; s_rready = granted m_rready; on handshake go to IDLE.
- WR_REQ: AW and W are forwarded independently; aw_done/w_done flags set on each handshake and block further forwarding on that channel; when both are done (same or different cycles) go to WR_RESP.
- WR_RESP: b channel routed as in RD_DATA; on handshake go to IDLE.
- Non-granted master: all ready and valid outputs 0. Slave valids are 0 outside their owning state.
- Data, addresses and responses pass through unchanged; no buffering.

## Timing

- Reset: state IDLE, ptr 0, done flags 0; every m*/s* valid and ready output 0.
- Arbitration costs 1 cycle: a request seen in IDLE at cycle N is presented on the s_ channel in cycle N+1.
- Back-to-back: from response handshake at N, back to IDLE at N+1, next slave valid at N+2.
- All forwarding is combinational within a state; no combinational path from a slave ready to any slave valid.
- A master must hold valid until its handshake; a master dropping awvalid before grant loses arbitration, with no error.
- Simultaneous requests from all four sources: served in ptr order, so each source gets one grant per four.
- Reset asserted mid-transaction: everything returns to IDLE on the next edge. The slave is reset together with the arbiter.

## Configuration

- AXIL_ARB_TIMEOUT_EN defined: a counter runs in RD_DATA/WR_RESP. When it reaches TIMEOUT_CYC with no slave response, the arbiter itself returns rresp/bresp = 2'b10 (SLVERR), with rdata 0, to the granted master and then goes to IDLE. A sticky flag `hung` then holds s_rready/s_bready = 1 outside RD_DATA/WR_RESP so that late responses are dropped. `hung` clears on the first dropped response.
- Not defined: no counter; the arbiter waits indefinitely for the slave.

## Structure

- Package axil_arb_pkg: state enum, resp constants (OKAY 2'b00, SLVERR 2'b10), request-index encoding.
- Sub-module rr_arb4: 4-bit request and ptr in, one-hot grant and index out; combinational only.

## Test plan

- m0 read 0x10, slave returns 0xDEADBEEF/OKAY after 3 cycles -> m0 sees rdata 0xDEADBEEF; m1 sees no rvalid; s_arvalid rises 1 cycle after m0_arvalid.
- m1 write 0x20 data 0xA5A5A5A5 wstrb 0xF, W arriving 4 cycles after AW -> one s_aw handshake and one s_w handshake, then bresp OKAY to m1.
- All four sources requesting continuously for 8 transactions -> grant order m0R, m0W, m1R, m1W, repeated twice.
- Slave holds s_rready-side response with rvalid low while m1 requests -> m1_arready stays 0 until the m0 read completes.
- AXIL_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, slave never responds to a read -> master gets rresp 2'b10 at cycle 16; a late s_rvalid is absorbed, and the next transaction completes normally.
- rst pulsed during WR_REQ -> all outputs 0 the next cycle; ptr 0; a fresh m0 read then succeeds.

Source files
------------

// File: rtl/axil_arb_pkg.sv
// Shared types and constants for the two-master AXI4-Lite arbiter.
package axil_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_REQ,
    ST_WR_RESP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Request index: bit 1 selects the master, bit 0 selects write over read.
  localparam int unsigned REQ_W = 4;
  localparam logic [1:0] REQ_M0_RD = 2'd0;
  localparam logic [1:0] REQ_M0_WR = 2'd1;
  localparam logic [1:0] REQ_M1_RD = 2'd2;
  localparam logic [1:0] REQ_M1_WR = 2'd3;

  function automatic logic req_master(input logic [1:0] idx);
    return idx[1];
  endfunction

  function automatic logic req_is_write(input logic [1:0] idx);
    return idx[0];
  endfunction

endpackage

// File: rtl/axil_arb2_rr_arb4.sv
// Combinational 4-way round-robin picker: first request at or after ptr wins.
module rr_arb4
  import axil_arb_pkg::*;
(
  input  logic [REQ_W-1:0] req_i,
  input  logic [1:0]       ptr_i,
  output logic [REQ_W-1:0] gnt_oh_o,
  output logic [1:0]       gnt_idx_o,
  output logic             gnt_any_o
);

  logic [1:0] idx;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    idx       = '0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_i + 2'(i);
      if (req_i[idx] && (gnt_oh_o == '0)) begin
        gnt_oh_o[idx] = 1'b1;
        gnt_idx_o     = idx;
      end
    end
  end

  assign gnt_any_o = |req_i;

endmodule

// File: rtl/axil_arb2.sv
// Two-master AXI4-Lite arbiter, one transaction in flight, round-robin over four sources.
// Optional response watchdog enabled by defining AXIL_ARB_TIMEOUT_EN.
module axil_arb2
  import axil_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_arvalid_i,
  output logic                m0_arready_o,
  input  logic [ADDR_W-1:0]   m0_araddr_i,
  output logic                m0_rvalid_o,
  input  logic                m0_rready_i,
  output logic [DATA_W-1:0]   m0_rdata_o,
  output logic [1:0]          m0_rresp_o,
  input  logic                m0_awvalid_i,
  output logic                m0_awready_o,
  input  logic [ADDR_W-1:0]   m0_awaddr_i,
  input  logic                m0_wvalid_i,
  output logic                m0_wready_o,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  input  logic [DATA_W/8-1:0] m0_wstrb_i,
  output logic                m0_bvalid_o,
  input  logic                m0_bready_i,
  output logic [1:0]          m0_bresp_o,
  input  logic                m1_arvalid_i,
  output logic                m1_arready_o,
  input  logic [ADDR_W-1:0]   m1_araddr_i,
  output logic                m1_rvalid_o,
  input  logic                m1_rready_i,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic [1:0]          m1_rresp_o,
  input  logic                m1_awvalid_i,
  output logic                m1_awready_o,
  input  logic [ADDR_W-1:0]   m1_awaddr_i,
  input  logic                m1_wvalid_i,
  output logic                m1_wready_o,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  input  logic [DATA_W/8-1:0] m1_wstrb_i,
  output logic                m1_bvalid_o,
  input  logic                m1_bready_i,
  output logic [1:0]          m1_bresp_o,
  output logic                s_arvalid_o,
  input  logic                s_arready_i,
  output logic [ADDR_W-1:0]   s_araddr_o,
  input  logic                s_rvalid_i,
  output logic                s_rready_o,
  input  logic [DATA_W-1:0]   s_rdata_i,
  input  logic [1:0]          s_rresp_i,
  output logic                s_awvalid_o,
  input  logic                s_awready_i,
  output logic [ADDR_W-1:0]   s_awaddr_o,
  output logic                s_wvalid_o,
  input  logic                s_wready_i,
  output logic [DATA_W-1:0]   s_wdata_o,
  output logic [DATA_W/8-1:0] s_wstrb_o,
  input  logic                s_bvalid_i,
  output logic                s_bready_o,
  input  logic [1:0]          s_bresp_i
);

  localparam int unsigned STRB_W = DATA_W / 8;

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic       gnt_m_q, gnt_m_d, gnt_rw_q, gnt_rw_d;
  logic       aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic       hung_q, hung_set_c, timed_out_c, resp_state_c;

  logic [REQ_W-1:0] req_c, gnt_oh_c;
  logic [1:0]       gnt_idx_c;
  logic             gnt_any_c;

  logic              sel_arvalid, sel_rready, sel_awvalid, sel_wvalid, sel_bready;
  logic [DATA_W-1:0] rdata_c;
  logic [1:0]        rresp_c, bresp_c;
  logic              arready_c, rvalid_c, awready_c, wready_c, bvalid_c;
  logic              s_arvalid_c, s_rready_c, s_awvalid_c, s_wvalid_c, s_bready_c;

  assign req_c = {m1_awvalid_i, m1_arvalid_i, m0_awvalid_i, m0_arvalid_i};

  rr_arb4 u_rr (
    .req_i     (req_c),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (gnt_oh_c),
    .gnt_idx_o (gnt_idx_c),
    .gnt_any_o (gnt_any_c)
  );

  // Granted-master input mux; payloads pass straight through.
  assign sel_arvalid = gnt_m_q ? m1_arvalid_i : m0_arvalid_i;
  assign sel_rready  = gnt_m_q ? m1_rready_i  : m0_rready_i;
  assign sel_awvalid = gnt_m_q ? m1_awvalid_i : m0_awvalid_i;
  assign sel_wvalid  = gnt_m_q ? m1_wvalid_i  : m0_wvalid_i;
  assign sel_bready  = gnt_m_q ? m1_bready_i  : m0_bready_i;
  assign s_araddr_o  = gnt_m_q ? m1_araddr_i  : m0_araddr_i;
  assign s_awaddr_o  = gnt_m_q ? m1_awaddr_i  : m0_awaddr_i;
  assign s_wdata_o   = gnt_m_q ? m1_wdata_i   : m0_wdata_i;
  assign s_wstrb_o   = gnt_m_q ? STRB_W'(m1_wstrb_i) : STRB_W'(m0_wstrb_i);

  assign resp_state_c = (state_q == ST_RD_DATA) || (state_q == ST_WR_RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      gnt_m_q   <= 1'b0;
      gnt_rw_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_m_q   <= gnt_m_d;
      gnt_rw_q  <= gnt_rw_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_m_d     = gnt_m_q;
    gnt_rw_d    = gnt_rw_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    hung_set_c  = 1'b0;
    arready_c   = 1'b0;
    rvalid_c    = 1'b0;
    rdata_c     = s_rdata_i;
    rresp_c     = s_rresp_i;
    awready_c   = 1'b0;
    wready_c    = 1'b0;
    bvalid_c    = 1'b0;
    bresp_c     = s_bresp_i;
    s_arvalid_c = 1'b0;
    s_rready_c  = 1'b0;
    s_awvalid_c = 1'b0;
    s_wvalid_c  = 1'b0;
    s_bready_c  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_any_c && (gnt_oh_c != '0)) begin
          gnt_m_d  = req_master(gnt_idx_c);
          gnt_rw_d = req_is_write(gnt_idx_c);
          ptr_d    = gnt_idx_c + 2'd1;
          state_d  = req_is_write(gnt_idx_c) ? ST_WR_REQ : ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: begin
        s_arvalid_c = sel_arvalid;
        arready_c   = s_arready_i;
        if (sel_arvalid && s_arready_i) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (timed_out_c) begin
          rvalid_c = 1'b1;
          rdata_c  = '0;
          rresp_c  = RESP_SLVERR;
          if (sel_rready) begin
            state_d    = ST_IDLE;
            hung_set_c = 1'b1;
          end
        end else begin
          rvalid_c   = s_rvalid_i;
          s_rready_c = sel_rready;
          if (s_rvalid_i && sel_rready) state_d = ST_IDLE;
        end
      end
      ST_WR_REQ: begin
        // Each channel stops forwarding once its own handshake has happened.
        s_awvalid_c = sel_awvalid & ~aw_done_q;
        awready_c   = s_awready_i & ~aw_done_q;
        s_wvalid_c  = sel_wvalid & ~w_done_q;
        wready_c    = s_wready_i & ~w_done_q;
        if (s_awvalid_c && s_awready_i) aw_done_d = 1'b1;
        if (s_wvalid_c && s_wready_i)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) begin
          state_d   = ST_WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      ST_WR_RESP: begin
        if (timed_out_c) begin
          bvalid_c = 1'b1;
          bresp_c  = RESP_SLVERR;
          if (sel_bready) begin
            state_d    = ST_IDLE;
            hung_set_c = 1'b1;
          end
        end else begin
          bvalid_c   = s_bvalid_i;
          s_bready_c = sel_bready;
          if (s_bvalid_i && sel_bready) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // After a watchdog abort, swallow the slave's late response.
    if (hung_q && !resp_state_c) begin
      s_rready_c = 1'b1;
      s_bready_c = 1'b1;
    end
  end

`ifdef AXIL_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q;

  assign timed_out_c = resp_state_c && (cnt_q == CNT_W'(TIMEOUT_CYC));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      hung_q <= 1'b0;
    end else begin
      if (!resp_state_c)    cnt_q <= '0;
      else if (!timed_out_c) cnt_q <= cnt_q + CNT_W'(1);
      if (hung_set_c)
        hung_q <= 1'b1;
      else if (hung_q && !resp_state_c && (s_rvalid_i || s_bvalid_i))
        hung_q <= 1'b0;
    end
  end
`else
  logic unused_c;
  assign timed_out_c = 1'b0;
  assign hung_q      = 1'b0;
  assign unused_c    = ^{TIMEOUT_CYC, hung_set_c, gnt_rw_q};
`endif

  assign m0_arready_o = arready_c & ~gnt_m_q;
  assign m1_arready_o = arready_c &  gnt_m_q;
  assign m0_rvalid_o  = rvalid_c  & ~gnt_m_q;
  assign m1_rvalid_o  = rvalid_c  &  gnt_m_q;
  assign m0_awready_o = awready_c & ~gnt_m_q;
  assign m1_awready_o = awready_c &  gnt_m_q;
  assign m0_wready_o  = wready_c  & ~gnt_m_q;
  assign m1_wready_o  = wready_c  &  gnt_m_q;
  assign m0_bvalid_o  = bvalid_c  & ~gnt_m_q;
  assign m1_bvalid_o  = bvalid_c  &  gnt_m_q;
  assign m0_rdata_o   = rdata_c;
  assign m1_rdata_o   = rdata_c;
  assign m0_rresp_o   = rresp_c;
  assign m1_rresp_o   = rresp_c;
  assign m0_bresp_o   = bresp_c;
  assign m1_bresp_o   = bresp_c;
  assign s_arvalid_o  = s_arvalid_c;
  assign s_rready_o   = s_rready_c;
  assign s_awvalid_o  = s_awvalid_c;
  assign s_wvalid_o   = s_wvalid_c;
  assign s_bready_o   = s_bready_c;

endmodule

// File: tb/tb_axil_arb2.sv
// Directed self-checking bench for axil_arb2; the watchdog case runs only with AXIL_ARB_TIMEOUT_EN.
module tb_axil_arb2;

  logic clk = 1'b0;
  logic rst;
  logic        m0_arvalid_i, m0_arready_o, m0_rvalid_o, m0_rready_i;
  logic [31:0] m0_araddr_i, m0_rdata_o, m0_awaddr_i, m0_wdata_i;
  logic [1:0]  m0_rresp_o, m0_bresp_o;
  logic        m0_awvalid_i, m0_awready_o, m0_wvalid_i, m0_wready_o, m0_bvalid_o, m0_bready_i;
  logic [3:0]  m0_wstrb_i;
  logic        m1_arvalid_i, m1_arready_o, m1_rvalid_o, m1_rready_i;
  logic [31:0] m1_araddr_i, m1_rdata_o, m1_awaddr_i, m1_wdata_i;
  logic [1:0]  m1_rresp_o, m1_bresp_o;
  logic        m1_awvalid_i, m1_awready_o, m1_wvalid_i, m1_wready_o, m1_bvalid_o, m1_bready_i;
  logic [3:0]  m1_wstrb_i;
  logic        s_arvalid_o, s_arready_i, s_rvalid_i, s_rready_o;
  logic [31:0] s_araddr_o, s_rdata_i, s_awaddr_o, s_wdata_o;
  logic [1:0]  s_rresp_i, s_bresp_i;
  logic        s_awvalid_o, s_awready_i, s_wvalid_o, s_wready_i, s_bvalid_i, s_bready_o;
  logic [3:0]  s_wstrb_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [14:0] vr_out;
  assign vr_out = {m0_arready_o, m0_rvalid_o, m0_awready_o, m0_wready_o, m0_bvalid_o,
                   m1_arready_o, m1_rvalid_o, m1_awready_o, m1_wready_o, m1_bvalid_o,
                   s_arvalid_o, s_rready_o, s_awvalid_o, s_wvalid_o, s_bready_o};

  axil_arb2 #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .m0_arvalid_i(m0_arvalid_i), .m0_arready_o(m0_arready_o), .m0_araddr_i(m0_araddr_i),
    .m0_rvalid_o(m0_rvalid_o), .m0_rready_i(m0_rready_i), .m0_rdata_o(m0_rdata_o), .m0_rresp_o(m0_rresp_o),
    .m0_awvalid_i(m0_awvalid_i), .m0_awready_o(m0_awready_o), .m0_awaddr_i(m0_awaddr_i),
    .m0_wvalid_i(m0_wvalid_i), .m0_wready_o(m0_wready_o), .m0_wdata_i(m0_wdata_i), .m0_wstrb_i(m0_wstrb_i),
    .m0_bvalid_o(m0_bvalid_o), .m0_bready_i(m0_bready_i), .m0_bresp_o(m0_bresp_o),
    .m1_arvalid_i(m1_arvalid_i), .m1_arready_o(m1_arready_o), .m1_araddr_i(m1_araddr_i),
    .m1_rvalid_o(m1_rvalid_o), .m1_rready_i(m1_rready_i), .m1_rdata_o(m1_rdata_o), .m1_rresp_o(m1_rresp_o),
    .m1_awvalid_i(m1_awvalid_i), .m1_awready_o(m1_awready_o), .m1_awaddr_i(m1_awaddr_i),
    .m1_wvalid_i(m1_wvalid_i), .m1_wready_o(m1_wready_o), .m1_wdata_i(m1_wdata_i), .m1_wstrb_i(m1_wstrb_i),
    .m1_bvalid_o(m1_bvalid_o), .m1_bready_i(m1_bready_i), .m1_bresp_o(m1_bresp_o),
    .s_arvalid_o(s_arvalid_o), .s_arready_i(s_arready_i), .s_araddr_o(s_araddr_o),
    .s_rvalid_i(s_rvalid_i), .s_rready_o(s_rready_o), .s_rdata_i(s_rdata_i), .s_rresp_i(s_rresp_i),
    .s_awvalid_o(s_awvalid_o), .s_awready_i(s_awready_i), .s_awaddr_o(s_awaddr_o),
    .s_wvalid_o(s_wvalid_o), .s_wready_i(s_wready_i), .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o),
    .s_bvalid_i(s_bvalid_i), .s_bready_o(s_bready_o), .s_bresp_i(s_bresp_i)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic       hs_aw, hs_w, seen, blocked;
    int         aw_n, w_n, n_g, n;
    logic [31:0] aw_a, w_d;
    logic [3:0]  w_s;
    logic [2:0]  order [8];

    rst = 1'b1;
    {m0_arvalid_i, m0_rready_i, m0_awvalid_i, m0_wvalid_i, m0_bready_i} = '0;
    {m1_arvalid_i, m1_rready_i, m1_awvalid_i, m1_wvalid_i, m1_bready_i} = '0;
    {m0_araddr_i, m0_awaddr_i, m0_wdata_i, m0_wstrb_i} = '0;
    {m1_araddr_i, m1_awaddr_i, m1_wdata_i, m1_wstrb_i} = '0;
    {s_arready_i, s_rvalid_i, s_awready_i, s_wready_i, s_bvalid_i} = '0;
    s_rdata_i = '0; s_rresp_i = '0; s_bresp_i = '0;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    check_eq("reset_outputs", 64'(vr_out), 64'h0);

    // m0 read 0x10, slave answers 3 cycles into the data phase
    m0_arvalid_i = 1'b1; m0_araddr_i = 32'h10; m0_rready_i = 1'b1; s_arready_i = 1'b1;
    #1;
    check_eq("rd_arv_not_same_cycle", 64'(s_arvalid_o), 64'h0);
    cyc();
    check_eq("rd_arv_next_cycle", 64'(s_arvalid_o), 64'h1);
    check_eq("rd_araddr", 64'(s_araddr_o), 64'h10);
    check_eq("rd_m0_arready", 64'(m0_arready_o), 64'h1);
    check_eq("rd_m1_arready", 64'(m1_arready_o), 64'h0);
    cyc();
    m0_arvalid_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      seen = seen | m0_rvalid_o | m1_rvalid_o;
      cyc();
    end
    check_eq("rd_no_early_rvalid", 64'(seen), 64'h0);
    s_rvalid_i = 1'b1; s_rdata_i = 32'hDEADBEEF; s_rresp_i = 2'b00;
    #1;
    check_eq("rd_m0_rvalid", 64'(m0_rvalid_o), 64'h1);
    check_eq("rd_m0_rdata", 64'(m0_rdata_o), 64'hDEADBEEF);
    check_eq("rd_m0_rresp", 64'(m0_rresp_o), 64'h0);
    check_eq("rd_m1_rvalid", 64'(m1_rvalid_o), 64'h0);
    check_eq("rd_s_rready", 64'(s_rready_o), 64'h1);
    cyc();
    s_rvalid_i = 1'b0; m0_rready_i = 1'b0;
    #1;
    check_eq("rd_back_idle", 64'(vr_out), 64'h0);

    // m1 write 0x20, W arrives 4 cycles after AW
    m1_awvalid_i = 1'b1; m1_awaddr_i = 32'h20; m1_bready_i = 1'b1;
    s_awready_i = 1'b1; s_wready_i = 1'b1;
    aw_n = 0; w_n = 0; aw_a = '0; w_d = '0; w_s = '0;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin m1_wvalid_i = 1'b1; m1_wdata_i = 32'hA5A5A5A5; m1_wstrb_i = 4'hF; end
      #1;
      hs_aw = s_awvalid_o & s_awready_i;
      hs_w  = s_wvalid_o & s_wready_i;
      if (hs_aw) begin aw_n++; aw_a = s_awaddr_o; end
      if (hs_w)  begin w_n++;  w_d = s_wdata_o; w_s = s_wstrb_o; end
      cyc();
      if (hs_aw) m1_awvalid_i = 1'b0;
      if (hs_w)  m1_wvalid_i  = 1'b0;
    end
    check_eq("wr_aw_count", 64'(aw_n), 64'd1);
    check_eq("wr_w_count", 64'(w_n), 64'd1);
    check_eq("wr_awaddr", 64'(aw_a), 64'h20);
    check_eq("wr_wdata", 64'(w_d), 64'hA5A5A5A5);
    check_eq("wr_wstrb", 64'(w_s), 64'hF);
    s_bvalid_i = 1'b1; s_bresp_i = 2'b00;
    #1;
    check_eq("wr_m1_bvalid", 64'(m1_bvalid_o), 64'h1);
    check_eq("wr_m1_bresp", 64'(m1_bresp_o), 64'h0);
    check_eq("wr_m0_bvalid", 64'(m0_bvalid_o), 64'h0);
    cyc();
    s_bvalid_i = 1'b0; m1_bready_i = 1'b0;
    #1;
    check_eq("wr_back_idle", 64'(m1_bvalid_o), 64'h0);

    // all four sources request continuously; slave always ready and responding
    m0_arvalid_i = 1'b1; m0_awvalid_i = 1'b1; m0_wvalid_i = 1'b1; m0_rready_i = 1'b1; m0_bready_i = 1'b1;
    m1_arvalid_i = 1'b1; m1_awvalid_i = 1'b1; m1_wvalid_i = 1'b1; m1_rready_i = 1'b1; m1_bready_i = 1'b1;
    s_arready_i = 1'b1; s_awready_i = 1'b1; s_wready_i = 1'b1; s_rvalid_i = 1'b1; s_bvalid_i = 1'b1;
    s_rdata_i = 32'h12345678;
    for (int k = 0; k < 8; k++) order[k] = 3'd7;
    n_g = 0;
    for (int i = 0; i < 60 && n_g < 8; i++) begin
      #1;
      if (m0_arready_o && n_g < 8) begin order[n_g] = 3'd0; n_g++; end
      if (m0_awready_o && n_g < 8) begin order[n_g] = 3'd1; n_g++; end
      if (m1_arready_o && n_g < 8) begin order[n_g] = 3'd2; n_g++; end
      if (m1_awready_o && n_g < 8) begin order[n_g] = 3'd3; n_g++; end
      if (n_g < 8) cyc();
    end
    check_eq("rr_grant_count", 64'(n_g), 64'd8);
    for (int k = 0; k < 8; k++)
      check_eq($sformatf("rr_order_%0d", k), 64'(order[k]), 64'(k % 4));
    cyc();
    {m0_arvalid_i, m0_awvalid_i, m0_wvalid_i, m1_arvalid_i, m1_awvalid_i, m1_wvalid_i} = '0;
    cyc();
    {s_arready_i, s_awready_i, s_wready_i, s_rvalid_i, s_bvalid_i} = '0;
    {m0_rready_i, m0_bready_i, m1_rready_i, m1_bready_i} = '0;
    #1;
    check_eq("rr_back_idle", 64'(vr_out), 64'h0);

    // m1 must wait while the slave stalls m0's read data
    m0_arvalid_i = 1'b1; m0_araddr_i = 32'h40; m0_rready_i = 1'b1; s_arready_i = 1'b1;
    cyc();
    cyc();
    m0_arvalid_i = 1'b0;
    m1_arvalid_i = 1'b1; m1_araddr_i = 32'h44; m1_rready_i = 1'b1;
    blocked = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      blocked = blocked | m1_arready_o | s_arvalid_o;
      cyc();
    end
    check_eq("stall_m1_blocked", 64'(blocked), 64'h0);
    s_rvalid_i = 1'b1; s_rdata_i = 32'h11223344;
    #1;
    check_eq("stall_m0_rdata", 64'(m0_rdata_o), 64'h11223344);
    cyc();
    s_rvalid_i = 1'b0;
    #1;
    check_eq("stall_idle_no_arready", 64'(m1_arready_o), 64'h0);
    cyc();
    check_eq("stall_m1_arready", 64'(m1_arready_o), 64'h1);
    check_eq("stall_m1_araddr", 64'(s_araddr_o), 64'h44);
    cyc();
    m1_arvalid_i = 1'b0;
    s_rvalid_i = 1'b1; s_rdata_i = 32'h55667788; s_rresp_i = 2'b00;
    #1;
    check_eq("stall_m1_rvalid", 64'(m1_rvalid_o), 64'h1);
    check_eq("stall_m0_rvalid", 64'(m0_rvalid_o), 64'h0);
    check_eq("stall_m1_rdata", 64'(m1_rdata_o), 64'h55667788);
    cyc();
    s_rvalid_i = 1'b0; m1_rready_i = 1'b0;

`ifdef AXIL_ARB_TIMEOUT_EN
    // slave never answers a read: arbiter returns SLVERR, then drops the late reply
    m0_arvalid_i = 1'b1; m0_araddr_i = 32'h80; m0_rready_i = 1'b0;
    cyc();
    cyc();
    m0_arvalid_i = 1'b0; m0_rready_i = 1'b1;
    n = 0;
    #1;
    while (!m0_rvalid_o && n < 40) begin
      cyc();
      #1;
      n++;
    end
    check_eq("to_cycles", 64'(n), 64'd16);
    check_eq("to_rresp", 64'(m0_rresp_o), 64'h2);
    check_eq("to_rdata", 64'(m0_rdata_o), 64'h0);
    check_eq("to_s_rready_off", 64'(s_rready_o), 64'h0);
    cyc();
    check_eq("to_hung_rready", 64'(s_rready_o), 64'h1);
    s_rvalid_i = 1'b1; s_rdata_i = 32'h00000BAD;
    #1;
    check_eq("to_late_absorbed", 64'(m0_rvalid_o), 64'h0);
    cyc();
    s_rvalid_i = 1'b0;
    #1;
    check_eq("to_hung_cleared", 64'(s_rready_o), 64'h0);
    m0_arvalid_i = 1'b1; m0_araddr_i = 32'h84;
    cyc();
    cyc();
    m0_arvalid_i = 1'b0;
    s_rvalid_i = 1'b1; s_rdata_i = 32'h0000600D; s_rresp_i = 2'b00;
    #1;
    check_eq("to_next_rdata", 64'(m0_rdata_o), 64'h600D);
    check_eq("to_next_rresp", 64'(m0_rresp_o), 64'h0);
    cyc();
    s_rvalid_i = 1'b0;
`endif

    // reset mid-write, then m0 read must beat m1 write (ptr back at 0)
    m0_awvalid_i = 1'b1; m0_awaddr_i = 32'h30; s_awready_i = 1'b0;
    cyc();
    check_eq("rst_pre_awvalid", 64'(s_awvalid_o), 64'h1);
    rst = 1'b1;
    cyc();
    check_eq("rst_outputs_zero", 64'(vr_out), 64'h0);
    rst = 1'b0;
    m0_awvalid_i = 1'b0;
    m0_arvalid_i = 1'b1; m0_araddr_i = 32'h50; m0_rready_i = 1'b1; s_arready_i = 1'b1;
    m1_awvalid_i = 1'b1; m1_awaddr_i = 32'h60;
    cyc();
    check_eq("rst_ptr0_m0r_wins", 64'(s_arvalid_o), 64'h1);
    check_eq("rst_m1w_loses", 64'(s_awvalid_o), 64'h0);
    m1_awvalid_i = 1'b0;
    cyc();
    m0_arvalid_i = 1'b0;
    s_rvalid_i = 1'b1; s_rdata_i = 32'hCAFEF00D;
    #1;
    check_eq("rst_fresh_rvalid", 64'(m0_rvalid_o), 64'h1);
    check_eq("rst_fresh_rdata", 64'(m0_rdata_o), 64'hCAFEF00D);
    cyc();
    s_rvalid_i = 1'b0;
    #1;
    check_eq("final_idle", 64'(vr_out), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
